// File: rtl/board_move_collector.sv
// Board-level collector: drains the per-column move FIFOs onto one valid/ready stream.
// Optional macro COLLECTOR_DROP_ZERO_EN: all-zero words are consumed but not emitted.
module board_move_collector #(
  parameter int NCOL    = 8,
  parameter int WORD_W  = 160,
  parameter int CNT_W   = 10,
  parameter int WDT_VAL = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NCOL-1:0]        col_done,
  input  logic [NCOL-1:0]        col_empty,
  input  logic [NCOL*WORD_W-1:0] col_data,
  output logic [NCOL-1:0]        col_rden,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  localparam int PTR_W = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int WDT_W = $clog2(WDT_VAL + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_VAL - 1);

  typedef enum logic [2:0] {IDLE, SCAN, READ, HOLD, DONE} state_e;

  state_e             state_q;
  logic [NCOL-1:0]    drained_q, drained_d;
  logic [PTR_W-1:0]   ptr_q, sel_idx;
  logic               sel_found;
  logic [WDT_W-1:0]   wdt_q;
  logic               wdt_expired;
  logic [WORD_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   word_count_q;
  logic [WORD_W-1:0]  col_word [NCOL];

  for (genvar g = 0; g < NCOL; g++) begin : g_unpack
    assign col_word[g] = col_data[g*WORD_W +: WORD_W];
  end

  // Lowest-index pending column wins: scan downward so the last hit is the lowest.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (col_done[i] && !drained_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(i);
      end
    end
  end

  // Watchdog saturates on its last count, so expiry stays visible until the round ends.
  assign wdt_expired = (wdt_q == WDT_LAST);

  // rden is decided in the same cycle as col_empty so an empty FIFO is never popped.
  always_comb begin
    drained_d = drained_q;
    col_rden  = '0;
    if (state_q == SCAN && sel_found) begin
      if (col_empty[sel_idx]) begin
        drained_d[sel_idx] = 1'b1;
      end else if (!wdt_expired) begin
        col_rden[sel_idx] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drained_q    <= '0;
      ptr_q        <= '0;
      wdt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      word_count_q <= '0;
    end else begin
      if ((state_q inside {SCAN, READ, HOLD}) && !wdt_expired) begin
        wdt_q <= wdt_q + 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= SCAN;
            drained_q    <= '0;
            word_count_q <= '0;
            timeout_q    <= 1'b0;
            wdt_q        <= '0;
          end
        end
        SCAN: begin
          drained_q <= drained_d;
          if (&drained_d) begin
            state_q <= DONE;
          end else if (wdt_expired) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
          end else if (|col_rden) begin
            ptr_q   <= sel_idx;
            state_q <= READ;
          end
        end
        READ: begin
`ifdef COLLECTOR_DROP_ZERO_EN
          if (col_word[ptr_q] == '0) begin
            if (wdt_expired) begin
              state_q   <= DONE;
              timeout_q <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end else begin
            out_data_q  <= col_word[ptr_q];
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
`else
          out_data_q  <= col_word[ptr_q];
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (word_count_q != '1) begin
              word_count_q <= word_count_q + 1'b1;
            end
            if (wdt_expired) begin
              state_q   <= DONE;
              timeout_q <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q inside {SCAN, READ, HOLD});
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_board_move_collector.sv
// Directed bench for board_move_collector: FIFO model per column plus an output scoreboard.
// A second instance with a 20-cycle watchdog covers the timeout paths.
module tb_board_move_collector;

  localparam int NCOL   = 8;
  localparam int WORD_W = 160;
  localparam int CNT_W  = 10;

  typedef logic [WORD_W-1:0] word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default watchdog)
  logic                   start     = 1'b0;
  logic                   out_ready = 1'b0;
  logic [NCOL-1:0]        col_done  = '0;
  logic [NCOL-1:0]        col_empty;
  logic [NCOL-1:0]        col_rden;
  logic [NCOL*WORD_W-1:0] col_data  = '0;
  word_t                  out_data;
  logic                   out_valid, busy, done, timeout;
  logic [CNT_W-1:0]       word_count;

  // Watchdog instance
  localparam word_t W_WORD = 160'h1234_5678_9abc_def0_0fed_cba9_8765_4321_a5a5_5a5a;
  logic                   w_start     = 1'b0;
  logic                   w_out_ready = 1'b0;
  logic [NCOL-1:0]        w_col_done  = '0;
  logic [NCOL-1:0]        w_col_empty = '1;
  logic [NCOL*WORD_W-1:0] w_col_data  = {{(NCOL-1)*WORD_W{1'b0}}, W_WORD};
  logic [NCOL-1:0]        w_col_rden;
  word_t                  w_out_data;
  logic                   w_out_valid, w_busy, w_done, w_timeout;
  logic [CNT_W-1:0]       w_word_count;

  board_move_collector #(.NCOL(NCOL), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .col_done(col_done), .col_empty(col_empty),
    .col_data(col_data), .col_rden(col_rden), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count), .busy(busy), .done(done), .timeout(timeout)
  );

  board_move_collector #(.NCOL(NCOL), .WORD_W(WORD_W), .CNT_W(CNT_W), .WDT_VAL(20)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .col_done(w_col_done), .col_empty(w_col_empty),
    .col_data(w_col_data), .col_rden(w_col_rden), .out_data(w_out_data), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .word_count(w_word_count), .busy(w_busy), .done(w_done),
    .timeout(w_timeout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check(tag, WORD_W'(obs), WORD_W'(exp));
  endtask

  // Non-show-ahead column FIFO model: data appears the cycle after rden.
  word_t mem [NCOL][64];
  int    wr_ptr [NCOL] = '{default: 0};
  int    rd_ptr [NCOL] = '{default: 0};

  for (genvar g = 0; g < NCOL; g++) begin : g_empty
    assign col_empty[g] = (rd_ptr[g] == wr_ptr[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) begin
        col_data[i*WORD_W +: WORD_W] <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  task automatic push(input int col, input word_t w);
    mem[col][wr_ptr[col]] = w;
    wr_ptr[col] = wr_ptr[col] + 1;
  endtask

  // Scoreboard and rden monitor, sampled on the falling edge.
  word_t exp_q [$];
  int    rden_cnt [NCOL] = '{default: 0};
  int    rden_bad     = 0;
  int    w_rden_total = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) rden_cnt[i]++;
    end
    if (!$onehot0(col_rden) || (|(col_rden & col_empty))) rden_bad++;
    if (|w_col_rden) w_rden_total++;
    if (out_valid && out_ready) begin
      check_int("sb_has_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
  end

  function automatic int rden_total();
    int s = 0;
    for (int i = 0; i < NCOL; i++) s += rden_cnt[i];
    return s;
  endfunction

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom} | word_t'(1);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain_sb(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_int(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check_int(tag, int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    word_t a, b, c, d, x, y;
    int    base, base0, n, exp_wc;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_timeout", int'(timeout), 0);
    check_int("rst_word_count", int'(word_count), 0);
    check_int("rst_col_rden", int'(col_rden), 0);
    check("rst_out_data", out_data, '0);

    // Single column, two words
    a = rand_word(); b = rand_word();
    push(0, a); push(0, b);
    exp_q.push_back(a); exp_q.push_back(b);
    base0 = rden_cnt[0]; base = rden_total();
    out_ready = 1'b1;
    pulse_start();
    col_done = 8'h01;
    drain_sb("t1_drain", 100);
    check_int("t1_not_done_yet", int'(done), 0);
    col_done = 8'hFF;
    wait_done("t1_done", 50);
    check_int("t1_rden_col0", rden_cnt[0] - base0, 2);
    check_int("t1_rden_total", rden_total() - base, 2);
    check_int("t1_word_count", int'(word_count), 2);
    check_int("t1_timeout", int'(timeout), 0);

    // Priority: columns 2 and 7 become done together
    c = rand_word(); d = rand_word();
    push(7, d); push(2, c);
    exp_q.push_back(c); exp_q.push_back(d);
    col_done = 8'h00;
    pulse_start();
    col_done = 8'h84;
    drain_sb("t2_drain", 100);
    col_done = 8'hFF;
    wait_done("t2_done", 50);
    check_int("t2_word_count", int'(word_count), 2);

    // Backpressure: ten stalled cycles in HOLD
    a = rand_word();
    push(4, a);
    exp_q.push_back(a);
    out_ready = 1'b0;
    col_done  = 8'h00;
    pulse_start();
    col_done = 8'h10;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check_int("t3_valid_seen", int'(out_valid), 1);
    base = rden_total();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_int("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_data", out_data, exp_q[0]);
    end
    check_int("t3_no_rden_in_hold", rden_total() - base, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check_int("t3_valid_dropped", int'(out_valid), 0);
    check_int("t3_sb_empty", exp_q.size(), 0);
    col_done = 8'hFF;
    wait_done("t3_done", 50);
    check_int("t3_word_count", int'(word_count), 1);

    // All columns done and empty
    base = rden_total();
    pulse_start();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) n++;
    end
    check_int("t4_done", int'(done), 1);
    check_int("t4_scan_cycles", n, 8);
    check_int("t4_word_count", int'(word_count), 0);
    check_int("t4_rden", rden_total() - base, 0);

    // Reset while a word is held
    a = rand_word();
    push(1, a);
    exp_q.push_back(a);
    out_ready = 1'b0;
    col_done  = 8'h00;
    pulse_start();
    col_done = 8'h02;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check_int("t5_valid_seen", int'(out_valid), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check_int("t5_rst_valid", int'(out_valid), 0);
    check_int("t5_rst_busy", int'(busy), 0);
    check_int("t5_rst_count", int'(word_count), 0);
    void'(exp_q.pop_front());
    reset = 1'b0;

    // Column holding one all-zero word among three
    x = rand_word(); y = rand_word();
    push(5, x); push(5, '0); push(5, y);
`ifdef COLLECTOR_DROP_ZERO_EN
    exp_q.push_back(x); exp_q.push_back(y);
    exp_wc = 2;
`else
    exp_q.push_back(x); exp_q.push_back('0); exp_q.push_back(y);
    exp_wc = 3;
`endif
    base = rden_total();
    out_ready = 1'b1;
    col_done  = 8'h00;
    pulse_start();
    col_done = 8'h20;
    drain_sb("t6_drain", 100);
    col_done = 8'hFF;
    wait_done("t6_done", 50);
    check_int("t6_word_count", int'(word_count), exp_wc);
    check_int("t6_rden", rden_total() - base, 3);
    check_int("t6_timeout", int'(timeout), 0);

    // Watchdog: column 3 never finishes
    w_col_done  = 8'hF7;
    w_col_empty = 8'hFF;
    w_out_ready = 1'b1;
    @(posedge clk); #1 w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (w_done) break;
      if (w_busy) n++;
    end
    check_int("t7_done", int'(w_done), 1);
    check_int("t7_busy_cycles", n, 20);
    check_int("t7_timeout", int'(w_timeout), 1);
    check_int("t7_word_count", int'(w_word_count), 0);

    // Watchdog expiring while a word waits for out_ready
    w_col_done  = 8'h00;
    w_out_ready = 1'b0;
    base = w_rden_total;
    @(posedge clk); #1 w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 w_col_done = 8'h01; w_col_empty = 8'hFE;
    repeat (15) @(negedge clk);
    check_int("t8_still_busy", int'(w_busy), 1);
    check_int("t8_pending_valid", int'(w_out_valid), 1);
    check("t8_pending_data", w_out_data, W_WORD);
    check_int("t8_no_timeout_yet", int'(w_timeout), 0);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    check_int("t8_done", int'(w_done), 1);
    check_int("t8_timeout", int'(w_timeout), 1);
    check_int("t8_word_count", int'(w_word_count), 1);
    check_int("t8_valid_low", int'(w_out_valid), 0);
    repeat (5) @(posedge clk);
    #1;
    check_int("t8_single_rden", w_rden_total - base, 1);

    check_int("rden_protocol", rden_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
